// File: rtl/arv_fetch_2.sv
// arv_fetch_2 : second instruction-fetch stage.
// Takes a PC from fetch 1, issues one outstanding read to instruction memory,
// and registers the returned word with its PC for decode. Flush kills any
// in-flight fetch; its response is swallowed in DRAIN.
// Optional build macro: ARV_FETCH_FAULT_EN (misaligned-PC and bus-error faults).
// ctrl_i packing: ctrl_i[1] = flush, ctrl_i[0] = stall.
module arv_fetch_2 #(
    parameter int unsigned          INSTR_W       = 32,
    parameter int unsigned          PHY_ADDR_SIZE = 32,
    parameter logic [31:0]          PC_RESET_ADDR = 32'h0000_0000,
    parameter logic [INSTR_W-1:0]   NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               ctrl_i,
    input  logic                     f1_valid_i,
    input  logic [PHY_ADDR_SIZE-1:0] f1_i,
    output logic                     f1_ready_o,
    output logic                     imem_req_valid_o,
    output logic [PHY_ADDR_SIZE-1:0] imem_req_addr_o,
    input  logic                     imem_req_ready_i,
    input  logic                     imem_rsp_valid_i,
    input  logic [INSTR_W-1:0]       imem_rsp_data_i,
    input  logic                     imem_rsp_err_i,
    output logic                     f2_valid_o,
    output logic [PHY_ADDR_SIZE-1:0] f2_o,
    output logic [INSTR_W-1:0]       f2_instr_o,
    output logic                     f2_fault_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [PHY_ADDR_SIZE-1:0] RST_PC = PC_RESET_ADDR[PHY_ADDR_SIZE-1:0];

    logic flush;
    logic stall;
    assign flush = ctrl_i[1];
    assign stall = ctrl_i[0];

    state_t                     state_q, state_d;
    logic [PHY_ADDR_SIZE-1:0]   addr_q, addr_d;
    logic                       kill_q, kill_d;
    logic                       req_valid_q, req_valid_d;
    logic                       f2_valid_q, f2_valid_d;
    logic [PHY_ADDR_SIZE-1:0]   f2_pc_q, f2_pc_d;
    logic [INSTR_W-1:0]         f2_instr_q, f2_instr_d;
    logic                       f2_fault_q, f2_fault_d;

    logic accept;
    logic [INSTR_W-1:0] rsp_instr;
    logic               rsp_fault;
    logic               misaligned;

`ifdef ARV_FETCH_FAULT_EN
    // A bus error replaces the word with a NOP and flags the fault.
    assign rsp_instr  = imem_rsp_err_i ? NOP_INSTR : imem_rsp_data_i;
    assign rsp_fault  = imem_rsp_err_i;
    assign misaligned = (f1_i[1:0] != 2'b00);
`else
    // Faults disabled: error and low PC bits are deliberately ignored.
    logic unused_err;
    assign unused_err = imem_rsp_err_i;
    assign rsp_instr  = imem_rsp_data_i;
    assign rsp_fault  = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Accept only when idle, not flushing, and the output slot is free or draining this cycle.
    always_comb begin
        f1_ready_o = (state_q == IDLE) && !flush && (!f2_valid_q || !stall);
    end

    assign accept = f1_valid_i && f1_ready_o;

    // Next-state, request and output-slot logic; flush overrides everything else.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        kill_d      = kill_q;
        req_valid_d = req_valid_q;
        f2_valid_d  = f2_valid_q;
        f2_pc_d     = f2_pc_q;
        f2_instr_d  = f2_instr_q;
        f2_fault_d  = f2_fault_q;

        // Decode takes the slot whenever it is not stalled.
        if (f2_valid_q && !stall) begin
            f2_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        // No memory access; fault goes straight to the slot.
                        f2_valid_d = 1'b1;
                        f2_pc_d    = f1_i;
                        f2_instr_d = NOP_INSTR;
                        f2_fault_d = 1'b1;
                    end else begin
                        addr_d      = f1_i;
                        req_valid_d = 1'b1;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                // A request once raised must complete; a flush only marks it dead.
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (imem_req_ready_i) begin
                    req_valid_d = 1'b0;
                    kill_d      = 1'b0;
                    state_d     = (kill_q || flush) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    // Response arriving with the flush is simply dropped.
                    state_d = imem_rsp_valid_i ? IDLE : DRAIN;
                end else if (imem_rsp_valid_i) begin
                    f2_valid_d = 1'b1;
                    f2_pc_d    = addr_q;
                    f2_instr_d = rsp_instr;
                    f2_fault_d = rsp_fault;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            f2_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= RST_PC;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            f2_valid_q  <= 1'b0;
            f2_pc_q     <= RST_PC;
            f2_instr_q  <= NOP_INSTR;
            f2_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            f2_valid_q  <= f2_valid_d;
            f2_pc_q     <= f2_pc_d;
            f2_instr_q  <= f2_instr_d;
            f2_fault_q  <= f2_fault_d;
        end
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = addr_q;
    assign f2_valid_o       = f2_valid_q;
    assign f2_o             = f2_pc_q;
    assign f2_instr_o       = f2_instr_q;
    assign f2_fault_o       = f2_fault_q;

endmodule

// File: tb/tb_arv_fetch_2.sv
// Directed bench for arv_fetch_2: hand-computed vectors for fetch timing,
// backpressure, stall hold, flush in REQ/WAIT and the optional fault path.
module tb_arv_fetch_2;

    localparam logic [31:0] RST_PC = 32'h0000_0200;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [1:0]  ctrl_i;
    logic        f1_valid_i;
    logic [31:0] f1_i;
    logic        f1_ready_o;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        f2_valid_o;
    logic [31:0] f2_o;
    logic [31:0] f2_instr_o;
    logic        f2_fault_o;

    int n_chk;
    int n_err;

    arv_fetch_2 #(
        .INSTR_W      (32),
        .PHY_ADDR_SIZE(32),
        .PC_RESET_ADDR(RST_PC),
        .NOP_INSTR    (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_i          (ctrl_i),
        .f1_valid_i      (f1_valid_i),
        .f1_i            (f1_i),
        .f1_ready_o      (f1_ready_o),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_addr_o (imem_req_addr_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .imem_rsp_err_i  (imem_rsp_err_i),
        .f2_valid_o      (f2_valid_o),
        .f2_o            (f2_o),
        .f2_instr_o      (f2_instr_o),
        .f2_fault_o      (f2_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one aligned PC for a single accepting edge.
    task automatic issue(input logic [31:0] pc);
        f1_valid_i = 1'b1;
        f1_i       = pc;
        #0;
        chk("acc_ready", 32'(f1_ready_o), 32'd1);
        tick();
        f1_valid_i = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc,
                              input logic [31:0] ins, input logic flt);
        chk({tag, "_vld"},   32'(f2_valid_o), 32'd1);
        chk({tag, "_pc"},    f2_o, pc);
        chk({tag, "_instr"}, f2_instr_o, ins);
        chk({tag, "_fault"}, 32'(f2_fault_o), 32'(flt));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst              = 1'b1;
        ctrl_i           = 2'b00;
        f1_valid_i       = 1'b0;
        f1_i             = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        imem_rsp_err_i   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #0;

        // Reset values
        chk("rst_ready", 32'(f1_ready_o), 32'd1);
        chk("rst_rqv",   32'(imem_req_valid_o), 32'd0);
        chk("rst_addr",  imem_req_addr_o, RST_PC);
        chk("rst_vld",   32'(f2_valid_o), 32'd0);
        chk("rst_pc",    f2_o, RST_PC);
        chk("rst_instr", f2_instr_o, NOP);
        chk("rst_fault", 32'(f2_fault_o), 32'd0);

        // Basic fetch: accept T, req T+1, rsp T+2, output T+3
        issue(32'h0000_1000);
        chk("b_rqv",   32'(imem_req_valid_o), 32'd1);
        chk("b_addr",  imem_req_addr_o, 32'h0000_1000);
        chk("b_busy",  32'(f1_ready_o), 32'd0);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        chk("b_rqv_lo", 32'(imem_req_valid_o), 32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0050_0093;
        #0;
        chk("b_vld_early", 32'(f2_valid_o), 32'd0);
        tick();
        imem_rsp_valid_i = 1'b0;
        expect_out("b", 32'h0000_1000, 32'h0050_0093, 1'b0);

        // Stall with a full slot holds it for 5 cycles
        ctrl_i = 2'b01;
        #0;
        chk("s_ready0", 32'(f1_ready_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("s_hold", 32'h0000_1000, 32'h0050_0093, 1'b0);
            chk("s_ready", 32'(f1_ready_o), 32'd0);
        end
        ctrl_i = 2'b00;
        #0;
        chk("s_release_ready", 32'(f1_ready_o), 32'd1);
        tick();
        chk("s_consumed", 32'(f2_valid_o), 32'd0);

        // Memory backpressure: request held stable 4 cycles
        issue(32'h0000_2000);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rqv",  32'(imem_req_valid_o), 32'd1);
            chk("bp_addr", imem_req_addr_o, 32'h0000_2000);
            tick();
        end
        imem_req_ready_i = 1'b1;
        #0;
        chk("bp_rqv_hs", 32'(imem_req_valid_o), 32'd1);
        tick();
        imem_req_ready_i = 1'b0;
        chk("bp_rqv_lo", 32'(imem_req_valid_o), 32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h00A0_0113;
        tick();
        imem_rsp_valid_i = 1'b0;
        expect_out("bp", 32'h0000_2000, 32'h00A0_0113, 1'b0);
        tick();
        chk("bp_consumed", 32'(f2_valid_o), 32'd0);

        // Flush in WAIT, then a stale response is swallowed
        issue(32'h0000_3000);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        ctrl_i = 2'b10;
        #0;
        chk("fw_ready_fl", 32'(f1_ready_o), 32'd0);
        tick();
        ctrl_i = 2'b00;
        #0;
        chk("fw_drain_ready", 32'(f1_ready_o), 32'd0);
        chk("fw_vld0", 32'(f2_valid_o), 32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("fw_vld1", 32'(f2_valid_o), 32'd0);
        chk("fw_idle_ready", 32'(f1_ready_o), 32'd1);
        issue(32'h0000_8000);
        chk("fw_addr", imem_req_addr_o, 32'h0000_8000);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0030_0193;
        tick();
        imem_rsp_valid_i = 1'b0;
        expect_out("fw_next", 32'h0000_8000, 32'h0030_0193, 1'b0);
        tick();

        // Flush in REQ while ready low; request completes, response discarded
        issue(32'h0000_4000);
        ctrl_i = 2'b10;
        tick();
        ctrl_i = 2'b00;
        chk("fr_rqv_held", 32'(imem_req_valid_o), 32'd1);
        chk("fr_addr", imem_req_addr_o, 32'h0000_4000);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        chk("fr_rqv_lo", 32'(imem_req_valid_o), 32'd0);
        chk("fr_drain_ready", 32'(f1_ready_o), 32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h1111_1111;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("fr_vld", 32'(f2_valid_o), 32'd0);
        chk("fr_ready", 32'(f1_ready_o), 32'd1);
        tick();
        chk("fr_vld2", 32'(f2_valid_o), 32'd0);

        // Stall during WAIT does not block capture; flush then clears a stalled slot
        issue(32'h0000_5000);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        ctrl_i = 2'b01;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0040_0213;
        tick();
        imem_rsp_valid_i = 1'b0;
        expect_out("sf", 32'h0000_5000, 32'h0040_0213, 1'b0);
        ctrl_i = 2'b11;
        #0;
        chk("sf_ready", 32'(f1_ready_o), 32'd0);
        tick();
        chk("sf_flushed", 32'(f2_valid_o), 32'd0);
        ctrl_i = 2'b00;
        tick();

`ifdef ARV_FETCH_FAULT_EN
        // Misaligned PC faults next cycle without a memory request
        issue(32'h0000_1002);
        chk("ma_rqv", 32'(imem_req_valid_o), 32'd0);
        expect_out("ma", 32'h0000_1002, NOP, 1'b1);
        tick();
        chk("ma_rqv2", 32'(imem_req_valid_o), 32'd0);
        // Bus error substitutes a NOP
        issue(32'h0000_1004);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0050_0093;
        imem_rsp_err_i   = 1'b1;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_err_i   = 1'b0;
        expect_out("err", 32'h0000_1004, NOP, 1'b1);
        tick();
`else
        // Faults disabled: bus error is ignored and data passes through
        issue(32'h0000_1004);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0050_0093;
        imem_rsp_err_i   = 1'b1;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_err_i   = 1'b0;
        expect_out("noerr", 32'h0000_1004, 32'h0050_0093, 1'b0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
